vedic_dot_acc: RTL and testbench
================================

// Module: vedic_dot_acc
// PURPOSE
//  Streaming dot-product stage around vedic_mult_8bit. Accepts LEN 8-bit operand
//  pairs over a valid/ready handshake, multiplies them through a registered
//  vedic_mult_8bit stage, and accumulates the 16-bit products.
//  Presents the sum on an output valid/ready port, then clears for the next batch.
//  Sits between the operand source and any consumer of multiplier results.
// PARAMETERS
//  LEN    4   products per batch; legal range >= 1
//  ACC_W  18  accumulator width; legal range >= 16; 18 is overflow-free for LEN=4
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand pair a/b is valid
//  in_ready   out  1      block accepts a pair this cycle
//  a          in   8      unsigned operand
//  b          in   8      unsigned operand
//  out_valid  out  1      acc holds a completed batch sum
//  out_ready  in   1      consumer takes the sum
//  acc        out  ACC_W  accumulated sum; meaningful only while out_valid=1
//  ovf        out  1      sticky: a batch sum exceeded 2^ACC_W-1; valid with out_valid
// BEHAVIOUR
//  - Reset values: state=ACC, cnt=0, all pipeline valid/last tags=0, acc=0, ovf=0.
//    Resulting outputs: in_ready=1, out_valid=0.
//  - Input handshake: a pair is accepted when in_valid & in_ready, on the rising edge.
//  - Pipeline: S1 registers a/b with v1 and last1, where last1=(cnt==LEN-1).
//    S2 registers the vedic_mult_8bit product of the S1 regs with v2 and last2.
//    S3: if v2, acc <= acc + prod, with wrap mod 2^ACC_W; a carry out sets ovf.
//  - cnt increments on each accepted pair. It wraps to 0 on the LEN-th pair.
//  - FSM, 3 states:
//    ACC: in_ready=1. On the LEN-th accept, go to FLUSH.
//    FLUSH: in_ready=0. When v2 & last2, the final add occurs and the state goes to HOLD.
//    HOLD: out_valid=1; acc and ovf are frozen. On out_ready, at the same edge:
//      acc<=0, ovf<=0, state<=ACC. in_ready is high the following cycle.
//  - Latency: the LEN-th handshake in cycle 0 gives out_valid=1 in cycle 3.
//  - Throughput: 1 pair per cycle within a batch. Batches do not overlap: no input
//    is accepted in FLUSH or HOLD.
//  - Bubbles: in_valid=0 in ACC inserts bubbles. v1/v2 gate the add, so the sum is unaffected.
//  - LEN=1: the first accept goes straight to FLUSH.
//  - out_ready high while not in HOLD: ignored.
//  - out_valid deasserts only via the out handshake or rst.
//  - rst mid-batch: partial sum, pipeline contents and tags are discarded immediately.
//  - in_valid/a/b are don't-care while in_ready=0.
//  - Handshakes during rst are ignored.
// STRUCTURE
//  - Shared package/include vedic_pkg: state encodings ST_ACC=2'd0, ST_FLUSH=2'd1,
//    ST_HOLD=2'd2, and a CLOG2 function for the cnt width.
//  - Sub-module: one instance of the existing vedic_mult_8bit, fed by the S1 regs.
//  - Everything else is inline: operand/product regs, cnt, FSM, accumulator.
// TESTING
//  1. Reset: assert rst mid-stream. Immediately: out_valid=0, acc=0, ovf=0, in_ready=1.
//  2. LEN=4, pairs (3,5),(7,11),(255,255),(0,9) back-to-back.
//     Expect out_valid in cycle 3 after the last pair; acc=65117, ovf=0.
//  3. Backpressure: hold out_ready=0 for 5 cycles in HOLD. acc stays 65117 and in_ready=0.
//     Then pulse out_ready: next cycle out_valid=0, acc=0, in_ready=1.
//  4. Bubbles: send the same 4 pairs as test 2 with in_valid gaps of 1-3 cycles.
//     Expect acc=65117, and out_valid 3 cycles after the last accept.
//  5. Overflow: ACC_W=16, LEN=2, pairs (255,255) x2. Expect acc=64514, ovf=1.
//     The next batch (1,1),(1,1) gives acc=2, ovf=0.
//  6. Reset mid-batch: accept 2 of 4 pairs, then pulse rst.
//     A fresh batch (1,2),(3,4),(5,6),(7,8) gives acc=100.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared definitions for the vedic multiplier datapath: FSM state encodings
// and the counter-width helper.
package vedic_pkg;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Never returns less than 1, so LEN=1 still gets a real counter bit.
  function automatic int CLOG2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/vedic_mult_8bit.sv
// Combinational 8x8 unsigned multiplier built Vedic-style (Urdhva Tiryagbhyam):
// 2x2 cells compose into 4x4 blocks, four of which form the 8x8 product.
module vedic_mult_8bit (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] s1;
    logic [1:0] s2;
    logic [3:0] r;
    r[0] = x[0] & y[0];
    s1   = {1'b0, x[1] & y[0]} + {1'b0, x[0] & y[1]};
    r[1] = s1[0];
    s2   = {1'b0, x[1] & y[1]} + {1'b0, s1[1]};
    r[2] = s2[0];
    r[3] = s2[1];
    return r;
  endfunction

  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] m0, m1, m2, m3;
    m0 = {4'b0, mul2(x[1:0], y[1:0])};
    m1 = {4'b0, mul2(x[3:2], y[1:0])};
    m2 = {4'b0, mul2(x[1:0], y[3:2])};
    m3 = {4'b0, mul2(x[3:2], y[3:2])};
    return m0 + (m1 << 2) + (m2 << 2) + (m3 << 4);
  endfunction

  // q[0]=lo*lo, q[1]=a_hi*b_lo, q[2]=a_lo*b_hi, q[3]=hi*hi
  logic [7:0] q [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_quad
      assign q[gi] = mul4(a[4*(gi%2) +: 4], b[4*(gi/2) +: 4]);
    end
  endgenerate

  assign p = {8'b0, q[0]} + {4'b0, q[1], 4'b0} + {4'b0, q[2], 4'b0} + {q[3], 8'b0};

endmodule

// File: rtl/vedic_dot_acc.sv
// Streaming dot-product: LEN operand pairs per batch go through a registered
// vedic multiplier and are summed; the batch sum is held until the consumer takes it.
module vedic_dot_acc
  import vedic_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  localparam int CNT_W = CLOG2(LEN);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       a1_reg, b1_reg;
  logic             v1_reg, last1_reg;
  logic [15:0]      prod;
  logic [15:0]      prod2_reg;
  logic             v2_reg, last2_reg;
  logic [ACC_W-1:0] acc_reg;
  logic             ovf_reg;
  logic             accept;
  logic             is_last;
  logic [ACC_W:0]   sum;

  assign accept  = in_valid & in_ready;
  assign is_last = (cnt_reg == CNT_W'(LEN - 1));
  assign sum     = {1'b0, acc_reg} + (ACC_W + 1)'(prod2_reg);

  vedic_mult_8bit u_mult (
    .a (a1_reg),
    .b (b1_reg),
    .p (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      a1_reg    <= '0;
      b1_reg    <= '0;
      v1_reg    <= 1'b0;
      last1_reg <= 1'b0;
      prod2_reg <= '0;
      v2_reg    <= 1'b0;
      last2_reg <= 1'b0;
    end else begin
      v1_reg    <= accept;
      last1_reg <= accept & is_last;
      if (accept) begin
        a1_reg  <= a;
        b1_reg  <= b;
        cnt_reg <= is_last ? '0 : cnt_reg + CNT_W'(1);
      end
      prod2_reg <= prod;
      v2_reg    <= v1_reg;
      last2_reg <= last1_reg;
    end
  end

  // The pipeline is always drained before HOLD, so no add can collide with the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (state_reg == ST_HOLD) begin
      if (out_ready) begin
        acc_reg <= '0;
        ovf_reg <= 1'b0;
      end
    end else if (v2_reg) begin
      acc_reg <= sum[ACC_W-1:0];
      if (sum[ACC_W]) ovf_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_ACC;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ST_ACC: begin
        in_ready = 1'b1;
        if (accept && is_last) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (v2_reg && last2_reg) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_ACC;
      end
      default: state_next = ST_ACC;
    endcase
  end

  assign acc = acc_reg;
  assign ovf = ovf_reg;

endmodule

// File: tb/tb_vedic_dot_acc.sv
// Bench for vedic_dot_acc: two instances (LEN=4/ACC_W=18 and LEN=2/ACC_W=16)
// checked every cycle against a batch-level model plus literal spot checks.
module tb_vedic_dot_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [7:0]  a, b;
  int          sel;

  logic        iv0, iv1, or0, or1;
  logic        ir0, ov0, ovf0, ir1, ov1, ovf1;
  logic [17:0] acc0;
  logic [15:0] acc1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance: phase 0=accepting, 1=draining, 2=holding result
  int     m_phase [2];
  int     m_cnt   [2];
  int     m_wt    [2];
  longint m_sum   [2];

  always #5 clk = ~clk;

  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign or0 = out_ready && (sel == 0);
  assign or1 = out_ready && (sel == 1);

  vedic_dot_acc #(.LEN(4), .ACC_W(18)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b),
    .out_valid(ov0), .out_ready(or0), .acc(acc0), .ovf(ovf0)
  );

  vedic_dot_acc #(.LEN(2), .ACC_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
    .out_valid(ov1), .out_ready(or1), .acc(acc1), .ovf(ovf1)
  );

  function automatic int lenv(input int m);
    return (m == 0) ? 4 : 2;
  endfunction

  function automatic int wv(input int m);
    return (m == 0) ? 18 : 16;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Batch model: sum the products of accepted pairs; the result appears
  // three cycles after the final accept and stays until taken.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        m_phase[m] <= 0;
        m_cnt[m]   <= 0;
        m_wt[m]    <= 0;
        m_sum[m]   <= 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        case (m_phase[m])
          0: if (in_valid && sel == m) begin
               m_sum[m] <= m_sum[m] + longint'(a) * longint'(b);
               if (m_cnt[m] == lenv(m) - 1) begin
                 m_cnt[m]   <= 0;
                 m_phase[m] <= 1;
                 m_wt[m]    <= 1;
               end else begin
                 m_cnt[m] <= m_cnt[m] + 1;
               end
             end
          1: if (m_wt[m] == 0) m_phase[m] <= 2;
             else m_wt[m] <= m_wt[m] - 1;
          default: if (out_ready && sel == m) begin
               m_phase[m] <= 0;
               m_sum[m]   <= 0;
             end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      longint act_acc, act_ovf, lim;
      act_acc = (m == 0) ? longint'(acc0) : longint'(acc1);
      act_ovf = (m == 0) ? longint'(ovf0) : longint'(ovf1);
      lim     = longint'(1) << wv(m);
      chk($sformatf("in_ready%0d", m), (m == 0) ? ir0 : ir1, m_phase[m] == 0);
      chk($sformatf("out_valid%0d", m), (m == 0) ? ov0 : ov1, m_phase[m] == 2);
      if (m_phase[m] == 2) begin
        chk($sformatf("acc%0d", m), act_acc, m_sum[m] % lim);
        chk($sformatf("ovf%0d", m), act_ovf, m_sum[m] >= lim);
      end else if (m_phase[m] == 0 && m_cnt[m] == 0) begin
        chk($sformatf("acc_idle%0d", m), act_acc, 0);
        chk($sformatf("ovf_idle%0d", m), act_ovf, 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int m, input int av, input int bv);
    int   k;
    logic r;
    sel = m; a = 8'(av); b = 8'(bv); in_valid = 1'b1; k = 0;
    do begin
      r = (m == 0) ? ir0 : ir1;
      cyc();
      k++;
    end while (!r && k < 20);
    if (!r) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // Called right after the last accept: out_valid must rise exactly in cycle 3.
  task automatic expect_result(input int m, input longint exp_acc, input longint exp_ovf);
    cyc();
    chk("latency_early", (m == 0) ? ov0 : ov1, 0);
    cyc();
    chk("latency", (m == 0) ? ov0 : ov1, 1);
    chk("result_acc", (m == 0) ? longint'(acc0) : longint'(acc1), exp_acc);
    chk("result_ovf", (m == 0) ? ovf0 : ovf1, exp_ovf);
  endtask

  task automatic take();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 0; a = '0; b = '0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    chk("reset_in_ready", ir0, 1);
    chk("reset_out_valid", ov0, 0);

    // Back-to-back batch, then backpressure in HOLD
    send(0, 3, 5); send(0, 7, 11); send(0, 255, 255); send(0, 0, 9);
    expect_result(0, 65117, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_acc", acc0, 65117);
      chk("bp_in_ready", ir0, 0);
    end
    take();
    chk("take_out_valid", ov0, 0);
    chk("take_acc", acc0, 0);
    chk("take_in_ready", ir0, 1);

    // Async reset while holding a result; handshakes during reset are ignored
    send(0, 3, 5); send(0, 7, 11); send(0, 255, 255); send(0, 0, 9);
    cyc(); cyc();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", ov0, 0);
    chk("rst_acc", acc0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_in_ready", ir0, 1);
    in_valid = 1'b1; a = 8'd9; b = 8'd9;
    cyc(); cyc();
    in_valid = 1'b0; rst = 1'b0;
    cyc();

    // Bubbles between accepts
    send(0, 3, 5);     repeat (1) cyc();
    send(0, 7, 11);    repeat (3) cyc();
    send(0, 255, 255); repeat (2) cyc();
    send(0, 0, 9);
    expect_result(0, 65117, 0);
    take();

    // Reset mid-batch discards partial sum
    send(0, 200, 200); send(0, 100, 100);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    cyc();
    send(0, 1, 2); send(0, 3, 4); send(0, 5, 6); send(0, 7, 8);
    expect_result(0, 100, 0);
    take();

    // Overflow on the narrow instance, then a clean batch
    send(1, 255, 255); send(1, 255, 255);
    expect_result(1, 64514, 1);
    cyc();
    take();
    send(1, 1, 1); send(1, 1, 1);
    expect_result(1, 2, 0);
    take();
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
